spi_shift_datapath: RTL and testbench

SPI_SHIFT_DATAPATH -- requirements
Module: spi_shift_datapath

---
 rtl/spi_shift_datapath_pkg.sv | 17 +
 rtl/spi_bit_counter.sv | 32 +++
 rtl/spi_shift_datapath.sv | 126 ++++++++++++
 tb/tb_spi_shift_datapath.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_shift_datapath_pkg.sv
// Shared SPI definitions: packet FSM state encoding and the packet_size width helper.
// Used by the shift datapath and by the SPI controller FSM so both agree on
// state codes and on how wide a bit-count field must be for a given packet width.
package spi_shift_datapath_pkg;

   typedef enum logic [1:0] {
      SPI_IDLE  = 2'd0,
      SPI_SHIFT = 2'd1,
      SPI_DONE  = 2'd2
   } spi_state_t;

   // A bit count must hold the value nbits itself, hence the extra bit.
   function automatic int spi_size_width(input int nbits);
      return $clog2(nbits) + 1;
   endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Purpose: counts sampled bits of the current packet; flags the posedge that completes it.
// Latency: count updates on the clock after inc; last is combinational from inc and count.
// Backpressure: none, follows the datapath enables.
//
// Ports: clk, reset (sync, active-high), clear (load), inc (sampling pulse in SHIFT),
//        size_reg (packet length), last (this inc brings the count to size_reg).
module spi_bit_counter #(
   parameter int size_w = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              inc,
   input  logic [size_w-1:0] size_reg,
   output logic              last
);

   logic [size_w-1:0] bit_cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         bit_cnt <= '0;
      end else if (inc) begin
         bit_cnt <= bit_cnt + size_w'(1);
      end
   end

   // Compare the post-increment value so the FSM can leave SHIFT on the same
   // edge that samples the final bit; the count therefore never passes size_reg.
   assign last = inc && ((bit_cnt + size_w'(1)) == size_reg);

endmodule

// File: rtl/spi_shift_datapath.sv
// Purpose: SPI master shift register; MSB-first MOSI out, MISO shifted in, per-packet size.
// Latency: send_val rises one cycle after the posedge pulse that samples the last bit.
// Backpressure: recv_rdy low while a packet is in flight; DONE holds send_msg until send_rdy.
//
// Ports: clk, reset (sync, active-high); recv_msg/recv_val/recv_rdy/packet_size load a
//        packet; sclk_posedge/sclk_negedge are controller pulses; miso in, mosi out
//        (registered); send_msg/send_val/send_rdy return the received word; busy.
module spi_shift_datapath
   import spi_shift_datapath_pkg::*;
#(
   parameter int nbits = 34
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [nbits-1:0]       recv_msg,
   input  logic                   recv_val,
   output logic                   recv_rdy,
   input  logic [$clog2(nbits):0] packet_size,
   input  logic                   sclk_posedge,
   input  logic                   sclk_negedge,
   input  logic                   miso,
   output logic                   mosi,
   output logic [nbits-1:0]       send_msg,
   output logic                   send_val,
   input  logic                   send_rdy,
   output logic                   busy
);

   localparam int                size_w  = spi_size_width(nbits);
   localparam logic [size_w-1:0] nbits_w = size_w'(nbits);

   spi_state_t        state;
   spi_state_t        state_nxt;
   logic [nbits-1:0]  shreg;
   logic [size_w-1:0] size_reg;
   logic [size_w-1:0] eff_size;
   logic [nbits-1:0]  load_word;
   logic [nbits-1:0]  drive_word;
   logic              load;
   logic              shift_en;
   logic              drive_en;
   logic              last_bit;

   // Zero or oversize requests fall back to the full width.
   assign eff_size = (packet_size == '0 || packet_size > nbits_w) ? nbits_w : packet_size;

   // Variable-position bit picks done as shifts so the index width is free.
   assign load_word  = recv_msg >> (eff_size - size_w'(1));
   assign drive_word = shreg >> (size_reg - size_w'(1));

   assign shift_en = (state == SPI_SHIFT) && sclk_posedge;
   assign drive_en = (state == SPI_SHIFT) && sclk_negedge;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SPI_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         SPI_IDLE: begin
            if (recv_val) begin
               load      = 1'b1;
               state_nxt = SPI_SHIFT;
            end
         end
         SPI_SHIFT: begin
            if (last_bit) begin
               state_nxt = SPI_DONE;
            end
         end
         SPI_DONE: begin
            if (send_rdy) begin
               state_nxt = SPI_IDLE;
            end
         end
         default: state_nxt = SPI_IDLE;
      endcase
   end

   assign recv_rdy = (state == SPI_IDLE);
   assign send_val = (state == SPI_DONE);
   assign busy     = (state != SPI_IDLE);

   // The negedge rule reads shreg before this edge's shift, so a coincident
   // posedge/negedge drives the bit that was on top before sampling.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg    <= '0;
         size_reg <= '0;
         mosi     <= 1'b0;
      end else if (load) begin
         shreg    <= recv_msg;
         size_reg <= eff_size;
         mosi     <= load_word[0];
      end else begin
         if (shift_en) begin
            shreg <= {shreg[nbits-2:0], miso};
         end
         if (drive_en) begin
            mosi <= drive_word[0];
         end
      end
   end

   spi_bit_counter #(
      .size_w (size_w)
   ) u_bit_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (load),
      .inc      (shift_en),
      .size_reg (size_reg),
      .last     (last_bit)
   );

   // Leftover transmit bits sit above the received ones; masking hides them.
   // A shift by size_reg == nbits yields zero, giving an all-ones mask.
   assign send_msg = shreg & ~({nbits{1'b1}} << size_reg);

endmodule

// File: tb/tb_spi_shift_datapath.sv
// Bench for spi_shift_datapath at nbits=8: directed packets plus random pulse traffic,
// checked every cycle against a packet-level model (bit position arithmetic and an
// accumulator of sampled MISO bits).
module tb_spi_shift_datapath;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] recv_msg;
   logic       recv_val;
   logic       recv_rdy;
   logic [3:0] packet_size;
   logic       sclk_posedge;
   logic       sclk_negedge;
   logic       miso;
   logic       mosi;
   logic [7:0] send_msg;
   logic       send_val;
   logic       send_rdy;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   // Model: phase 0 = waiting for a load, 1 = packet in flight, 2 = result pending.
   int         m_phase = 0;
   int         m_eff   = 8;
   int         m_k     = 0;
   logic [7:0] m_msg   = '0;
   logic [7:0] m_rx    = '0;
   logic       m_mosi  = 1'b0;
   int         m_sends = 0;
   int         dut_sends = 0;

   always #5 clk = ~clk;

   spi_shift_datapath #(
      .nbits (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .recv_msg     (recv_msg),
      .recv_val     (recv_val),
      .recv_rdy     (recv_rdy),
      .packet_size  (packet_size),
      .sclk_posedge (sclk_posedge),
      .sclk_negedge (sclk_negedge),
      .miso         (miso),
      .mosi         (mosi),
      .send_msg     (send_msg),
      .send_val     (send_val),
      .send_rdy     (send_rdy),
      .busy         (busy)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, advance the model, clock, compare all outputs.
   task automatic step(input logic rst, input logic rv, input logic [7:0] msg,
                       input logic [3:0] ps, input logic pos, input logic neg,
                       input logic mi, input logic sr);
      reset        = rst;
      recv_val     = rv;
      recv_msg     = msg;
      packet_size  = ps;
      sclk_posedge = pos;
      sclk_negedge = neg;
      miso         = mi;
      send_rdy     = sr;
      if (!rst && send_val && send_rdy) dut_sends++;
      if (rst) begin
         m_phase = 0;
         m_mosi  = 1'b0;
      end else begin
         case (m_phase)
            0: if (rv) begin
               m_eff   = (ps == 0 || ps > 8) ? 8 : int'(ps);
               m_msg   = msg;
               m_k     = 0;
               m_rx    = '0;
               m_mosi  = msg[m_eff-1];
               m_phase = 1;
            end
            1: begin
               // Bit on top of the window after m_k samples is msg[eff-1-m_k].
               if (neg) m_mosi = m_msg[m_eff-1-m_k];
               if (pos) begin
                  m_rx = {m_rx[6:0], mi};
                  m_k++;
                  if (m_k == m_eff) m_phase = 2;
               end
            end
            default: if (sr) begin
               m_phase = 0;
               m_sends++;
            end
         endcase
      end
      @(posedge clk);
      #1;
      check_eq("recv_rdy", recv_rdy, m_phase == 0);
      check_eq("send_val", send_val, m_phase == 2);
      check_eq("busy", busy, m_phase != 0);
      check_eq("mosi", mosi, m_mosi);
      if (m_phase == 2) check_eq("send_msg", send_msg, m_rx);
   endtask

   task automatic load(input logic [7:0] msg, input logic [3:0] ps);
      step(1'b0, 1'b1, msg, ps, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulse(input logic pos, input logic neg, input logic mi);
      step(1'b0, 1'b0, 8'h00, 4'd0, pos, neg, mi, 1'b0);
   endtask

   task automatic handshake();
      step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [7:0] seq;
      logic [2:0] bits3;
      int         n;

      // Reset and idle state
      step(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'hFF, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
      check_eq("rst_mosi", mosi, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("rst_recv_rdy", recv_rdy, 1'b1);

      // 0xA5, 8 bits, MISO tied high
      load(8'hA5, 4'd8);
      seq = '0;
      for (int i = 0; i < 8; i++) begin
         seq = {seq[6:0], mosi};
         pulse(1'b1, 1'b0, 1'b1);
         pulse(1'b0, 1'b1, 1'b0);
      end
      check_eq("a5_mosi_seq", seq, 8'hA5);
      check_eq("a5_send_msg", send_msg, 8'hFF);
      handshake();

      // 0x05, 3 bits, MISO 1,0,1
      load(8'h05, 4'd3);
      bits3 = 3'b101;
      seq   = '0;
      for (int i = 0; i < 3; i++) begin
         seq = {seq[6:0], mosi};
         pulse(1'b1, 1'b0, bits3[2-i]);
         if (i < 2) begin
            check_eq("s3_not_done", send_val, 1'b0);
            pulse(1'b0, 1'b1, 1'b0);
         end
      end
      check_eq("s3_latency", send_val, 1'b1);
      check_eq("s3_mosi_seq", seq, 8'h05);
      check_eq("s3_send_msg", send_msg, 8'h05);
      handshake();

      // packet_size 0 clamps to 8; count sampling pulses until completion
      load(8'h3C, 4'd0);
      n = 0;
      for (int i = 0; i < 12 && !send_val; i++) begin
         pulse(1'b1, 1'b0, 1'($urandom_range(0, 1)));
         n++;
         if (!send_val) pulse(1'b0, 1'b1, 1'b0);
      end
      check_eq("clamp_posedges", n, 8);

      // Stall in DONE with stray pulses and a pending load request
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 8'h99, 4'd4, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
         check_eq("stall_recv_rdy", recv_rdy, 1'b0);
      end

      // recv_val held through the handshake: reload one cycle later
      step(1'b0, 1'b1, 8'h6B, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("hs_recv_rdy", recv_rdy, 1'b1);
      step(1'b0, 1'b1, 8'h6B, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("reload_busy", busy, 1'b1);

      // Reset after 4 of 8 samples, including a coincident pulse pair
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b1, 1'b1, 1'b1);
      pulse(1'b1, 1'b0, 1'b1);
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("midrst_mosi", mosi, 1'b0);
      check_eq("midrst_recv_rdy", recv_rdy, 1'b1);
      check_eq("midrst_send_val", send_val, 1'b0);
      for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1, 1'b1);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 2) == 0,
              8'($urandom),
              4'($urandom_range(0, 15)),
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0,
              1'($urandom_range(0, 1)),
              $urandom_range(0, 1) == 0);
      end
      check_eq("send_count", dut_sends, m_sends);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
